sd_block_buffer: RTL and testbench

- Downstream consumer of the SD SPI reader. Captures each 512-byte sector streamed on InputData/InputDataClock while EnableVideoRead is high.
- Stores each sector into one of two ping-pong banks and serves stored bytes to the video side through a random-access read port.
- Generates the sector address (InputAddress) the reader fetches next, looping over a fixed sector range.

---
 rtl/sd_block_buffer_if.sv | 51 +++++
 rtl/sd_block_buffer.sv | 177 +++++++++++++++++
 tb/tb_sd_block_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_buffer_if.sv
// rtl/sd_block_buffer_if.sv - Bus bundle between the SD reader / video side and sd_block_buffer
//
// Purpose: groups the reader byte stream, sector address, and video read-port
// signals so they can be passed as a single port.
//   slave  : the buffer side. It receives the reader stream and the video read
//            requests, and drives the sector address, read data and status pulses.
//   master : the environment side, with the opposite directions.
// Signals:
//   InputData[7:0], InputDataClock, EnableVideoRead : reader byte stream (asynchronous)
//   InputAddress[15:0]                              : next sector to fetch
//   PixelAddress[8:0], PixelData[7:0]               : random-access read port
//   BankValid, BankRelease                          : read-bank ownership handshake
//   BlockError, FrameWrap                           : one-cycle status pulses
interface sd_block_buffer_if;
  logic [7:0]  InputData;
  logic        InputDataClock;
  logic        EnableVideoRead;
  logic [15:0] InputAddress;
  logic [8:0]  PixelAddress;
  logic [7:0]  PixelData;
  logic        BankValid;
  logic        BankRelease;
  logic        BlockError;
  logic        FrameWrap;

  modport slave (
    input  InputData,
    input  InputDataClock,
    input  EnableVideoRead,
    input  PixelAddress,
    input  BankRelease,
    output InputAddress,
    output PixelData,
    output BankValid,
    output BlockError,
    output FrameWrap
  );

  modport master (
    output InputData,
    output InputDataClock,
    output EnableVideoRead,
    output PixelAddress,
    output BankRelease,
    input  InputAddress,
    input  PixelData,
    input  BankValid,
    input  BlockError,
    input  FrameWrap
  );
endinterface

// File: rtl/sd_block_buffer.sv
// rtl/sd_block_buffer.sv - Ping-pong sector buffer between the SD SPI reader and the video reader
//
// Purpose: captures each streamed sector into one of two banks, hands complete
// banks to the video side, and generates the looping sector address.
// Ports:
//   MasterCLK : system clock (posedge)
//   Reset     : synchronous, active-high
//   bus       : sd_block_buffer_if.slave (reader stream, read port, status)
module sd_block_buffer #(
  parameter int unsigned BLOCK_BYTES  = 512,
  parameter int unsigned SKIP_BYTES   = 1,
  parameter int unsigned START_SECTOR = 0,
  parameter int unsigned SECTOR_COUNT = 150
) (
  input logic              MasterCLK,
  input logic              Reset,
  sd_block_buffer_if.slave bus
);

  localparam int AW = $clog2(BLOCK_BYTES);
  localparam int PW = $clog2(BLOCK_BYTES + 1);
  localparam int SW = $clog2(SKIP_BYTES + 2);
  localparam logic [PW-1:0] PTR_FULL = PW'(BLOCK_BYTES);
  localparam logic [SW-1:0] SKIP_N   = SW'(SKIP_BYTES);
  localparam logic [15:0]   FIRST    = 16'(START_SECTOR);
  localparam logic [15:0]   LAST     = 16'(START_SECTOR + SECTOR_COUNT - 1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DROP} state_t;

  // Synchronisers are deliberately left out of reset so that an enable which
  // is already high when reset is released looks steady, rather than like a
  // fresh rise, and the partially streamed sector is skipped.
  logic [2:0] dclk_sync;
  logic [2:0] en_sync;
  logic [7:0] data_s1;
  logic [7:0] data_s2;

  always_ff @(posedge MasterCLK) begin
    dclk_sync <= {dclk_sync[1:0], bus.InputDataClock};
    en_sync   <= {en_sync[1:0], bus.EnableVideoRead};
    data_s1   <= bus.InputData;
    data_s2   <= data_s1;
  end

  logic strobe;
  logic en_rise;
  logic en_fall;

  assign strobe  = dclk_sync[1] & ~dclk_sync[2];
  assign en_rise = en_sync[1] & ~en_sync[2];
  assign en_fall = ~en_sync[1] & en_sync[2];

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   wr_ptr;
  logic [SW-1:0]   skip_cnt;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic [1:0]      full_next;
  logic [15:0]     input_address;
  logic            block_error;
  logic            frame_wrap;
  logic [7:0]      pixel_data;

  logic            clear_ctr;
  logic            do_skip;
  logic            do_write;
  logic            commit_ok;
  logic            sector_err;
  logic            release_ok;

  // State register
  always_ff @(posedge MasterCLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_rise) state_next = full[wr_bank] ? DROP : FILL;
      FILL:    if (en_fall) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      DROP:    if (en_fall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    clear_ctr  = 1'b0;
    do_skip    = 1'b0;
    do_write   = 1'b0;
    commit_ok  = 1'b0;
    sector_err = 1'b0;
    case (state)
      IDLE: clear_ctr = en_rise;
      FILL: begin
        if (strobe) begin
          if (skip_cnt < SKIP_N)        do_skip  = 1'b1;
          else if (wr_ptr < PTR_FULL)   do_write = 1'b1;
        end
      end
      COMMIT: begin
        commit_ok  = (wr_ptr == PTR_FULL);
        sector_err = (wr_ptr != PTR_FULL);
      end
      DROP:    sector_err = en_fall;
      default: ;
    endcase
  end

  // Commit and release act on separate flags; a commit always targets a bank
  // that was empty when its capture started, so the two never collide.
  assign release_ok = bus.BankRelease & full[rd_bank];

  always_comb begin
    full_next = full;
    if (release_ok) full_next[rd_bank] = 1'b0;
    if (commit_ok)  full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      wr_ptr        <= '0;
      skip_cnt      <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full          <= 2'b00;
      input_address <= FIRST;
      block_error   <= 1'b0;
      frame_wrap    <= 1'b0;
    end else begin
      block_error <= sector_err;
      frame_wrap  <= 1'b0;
      full        <= full_next;
      if (clear_ctr) begin
        wr_ptr   <= '0;
        skip_cnt <= '0;
      end
      if (do_skip)  skip_cnt <= skip_cnt + 1'b1;
      if (do_write) wr_ptr   <= wr_ptr + 1'b1;
      if (commit_ok) begin
        wr_bank <= ~wr_bank;
        if (input_address == LAST) begin
          input_address <= FIRST;
          frame_wrap    <= 1'b1;
        end else begin
          input_address <= input_address + 16'd1;
        end
      end
      if (release_ok) rd_bank <= ~rd_bank;
    end
  end

  // Two banks back to back; the bank select is the top address bit.
  logic [7:0] mem [0:2*BLOCK_BYTES-1];

  always_ff @(posedge MasterCLK) begin
    if (do_write) mem[{wr_bank, wr_ptr[AW-1:0]}] <= data_s2;
  end

  // Registered read: a same-cycle write to the same location returns old data.
  always_ff @(posedge MasterCLK) begin
    if (Reset) pixel_data <= 8'h00;
    else       pixel_data <= mem[{rd_bank, bus.PixelAddress[AW-1:0]}];
  end

  assign bus.InputAddress = input_address;
  assign bus.PixelData    = pixel_data;
  assign bus.BankValid    = full[rd_bank];
  assign bus.BlockError   = block_error;
  assign bus.FrameWrap    = frame_wrap;

endmodule

// File: tb/tb_sd_block_buffer.sv
// tb/tb_sd_block_buffer.sv - Directed self-checking bench for sd_block_buffer
module tb_sd_block_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       dclk;
  logic       en;
  logic [8:0] pa;
  logic       rel;

  int n_cmp = 0;
  int n_bad = 0;
  int err_a = 0;
  int wrap_a = 0;
  int wrap_b = 0;

  sd_block_buffer_if ifa ();
  sd_block_buffer_if ifb ();

  assign ifa.InputData       = data;
  assign ifa.InputDataClock  = dclk;
  assign ifa.EnableVideoRead = en;
  assign ifa.PixelAddress    = pa;
  assign ifa.BankRelease     = rel;
  assign ifb.InputData       = data;
  assign ifb.InputDataClock  = dclk;
  assign ifb.EnableVideoRead = en;
  assign ifb.PixelAddress    = pa;
  assign ifb.BankRelease     = rel;

  sd_block_buffer #(.SECTOR_COUNT(150)) dut_a (.MasterCLK(clk), .Reset(rst), .bus(ifa));
  sd_block_buffer #(.SECTOR_COUNT(3))   dut_b (.MasterCLK(clk), .Reset(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifa.BlockError === 1'b1) err_a++;
    if (ifa.FrameWrap === 1'b1)  wrap_a++;
    if (ifb.FrameWrap === 1'b1)  wrap_b++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    cyc(4);
    dclk = 1'b1;
    cyc(4);
    dclk = 1'b0;
  endtask

  // Token byte, n payload bytes of ((i+add)&0xFF)^xr, then enable fall.
  // With rel_at_commit the release pulse lands on the COMMIT cycle.
  task automatic send_sector(input int n, input int add, input int xr, input bit rel_at_commit);
    logic [7:0] b;
    en = 1'b1;
    cyc(8);
    send_byte(8'hFE);
    for (int i = 0; i < n; i++) begin
      b = 8'((i + add) & 255) ^ 8'(xr);
      send_byte(b);
    end
    cyc(4);
    en = 1'b0;
    if (rel_at_commit) begin
      cyc(3);
      rel = 1'b1;
      cyc(1);
      rel = 1'b0;
    end
    cyc(6);
  endtask

  task automatic release_pulse();
    rel = 1'b1;
    cyc(1);
    rel = 1'b0;
    cyc(1);
  endtask

  task automatic pix(input logic [8:0] a, input logic [7:0] exp, input string tag);
    pa = a;
    cyc(1);
    check(tag, 32'(ifa.PixelData), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; dclk = 1'b0; en = 1'b0; pa = 9'h000; rel = 1'b0;
    cyc(4);
    check("rst_addr", 32'(ifa.InputAddress), 32'h0);
    check("rst_valid", 32'(ifa.BankValid), 32'h0);
    check("rst_pixel", 32'(ifa.PixelData), 32'h0);
    check("rst_err", 32'(ifa.BlockError), 32'h0);
    check("rst_wrap", 32'(ifa.FrameWrap), 32'h0);
    check("rst_addr_b", 32'(ifb.InputAddress), 32'h0);
    rst = 1'b0;
    cyc(2);

    // First full sector into bank 0
    send_sector(512, 0, 0, 1'b0);
    check("s1_valid", 32'(ifa.BankValid), 32'h1);
    check("s1_addr", 32'(ifa.InputAddress), 32'd1);
    check("s1_addr_b", 32'(ifb.InputAddress), 32'd1);
    check("s1_err", 32'(err_a), 32'd0);
    pix(9'h1FF, 8'hFF, "s1_pix_1ff");
    pix(9'h005, 8'h05, "s1_pix_005");

    // Second sector fills bank 1, third must be dropped
    send_sector(512, 8'h40, 0, 1'b0);
    check("s2_addr", 32'(ifa.InputAddress), 32'd2);
    check("s2_addr_b", 32'(ifb.InputAddress), 32'd2);
    send_sector(512, 0, 8'hA5, 1'b0);
    check("drop_err", 32'(err_a), 32'd1);
    check("drop_addr", 32'(ifa.InputAddress), 32'd2);
    check("drop_valid", 32'(ifa.BankValid), 32'h1);
    pix(9'h1FF, 8'hFF, "drop_bank0_intact");
    release_pulse();
    check("rel1_valid", 32'(ifa.BankValid), 32'h1);
    pix(9'h000, 8'h40, "rel1_bank1_pix");

    // Re-sent third sector goes into bank 0; dut_b wraps here
    send_sector(512, 0, 8'hA5, 1'b0);
    check("s3_addr", 32'(ifa.InputAddress), 32'd3);
    check("s3_addr_b", 32'(ifb.InputAddress), 32'd0);
    check("s3_wrap_b", 32'(wrap_b), 32'd1);
    check("s3_wrap_a", 32'(wrap_a), 32'd0);
    check("s3_err", 32'(err_a), 32'd1);
    release_pulse();
    check("rel2_valid", 32'(ifa.BankValid), 32'h1);
    pix(9'h000, 8'hA5, "s3_pix_000");
    pix(9'h1FF, 8'h5A, "s3_pix_1ff");
    release_pulse();
    check("rel3_valid", 32'(ifa.BankValid), 32'h0);

    // Fourth sector into bank 1
    send_sector(512, 8'h10, 0, 1'b0);
    check("s4_addr", 32'(ifa.InputAddress), 32'd4);
    check("s4_addr_b", 32'(ifb.InputAddress), 32'd1);
    check("s4_wrap_b", 32'(wrap_b), 32'd1);
    check("s4_valid", 32'(ifa.BankValid), 32'h1);
    pix(9'h001, 8'h11, "s4_pix_001");

    // Short sector: 300 payload bytes
    send_sector(300, 0, 0, 1'b0);
    check("short_err", 32'(err_a), 32'd2);
    check("short_valid", 32'(ifa.BankValid), 32'h1);
    check("short_addr", 32'(ifa.InputAddress), 32'd4);

    // Release, then a release with nothing valid must be ignored
    release_pulse();
    check("rel4_valid", 32'(ifa.BankValid), 32'h0);
    release_pulse();
    check("idle_rel_valid", 32'(ifa.BankValid), 32'h0);
    send_sector(512, 8'h20, 0, 1'b0);
    check("s5_valid", 32'(ifa.BankValid), 32'h1);
    check("s5_addr", 32'(ifa.InputAddress), 32'd5);
    pix(9'h000, 8'h20, "s5_pix_000");

    // Release of bank 0 coinciding with commit into bank 1
    send_sector(512, 8'h30, 0, 1'b1);
    check("sim_valid", 32'(ifa.BankValid), 32'h1);
    check("sim_addr", 32'(ifa.InputAddress), 32'd6);
    pix(9'h000, 8'h30, "sim_pix_000");
    release_pulse();
    check("sim_bank0_freed", 32'(ifa.BankValid), 32'h0);

    // Reset in the middle of a sector while enable stays high
    en = 1'b1;
    cyc(8);
    send_byte(8'hFE);
    for (int i = 0; i < 200; i++) send_byte(8'(i));
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_valid", 32'(ifa.BankValid), 32'h0);
    check("mid_rst_addr", 32'(ifa.InputAddress), 32'd0);
    for (int i = 200; i < 220; i++) send_byte(8'(i));
    cyc(4);
    en = 1'b0;
    cyc(8);
    check("mid_rst_no_commit", 32'(ifa.BankValid), 32'h0);
    check("mid_rst_no_err", 32'(err_a), 32'd2);
    check("mid_rst_addr2", 32'(ifa.InputAddress), 32'd0);
    send_sector(512, 7, 0, 1'b0);
    check("fresh_valid", 32'(ifa.BankValid), 32'h1);
    check("fresh_addr", 32'(ifa.InputAddress), 32'd1);
    pix(9'h000, 8'h07, "fresh_pix_000");
    pix(9'h1FF, 8'h06, "fresh_pix_1ff");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
